// File: rtl/iter_mul_hs.sv
// rtl/iter_mul_hs.sv - iterative shift-add multiplier with start/busy/done handshake
//
// Purpose:
//   Computes the 2*WIDTH-bit product of two WIDTH-bit operands.
//   It forms one partial product per clock.
//   This block is the multiply engine behind the ALU multicycle path.
//
// Configuration:
//   ITER_MUL_SIGNED_EN
//     When defined, sgn selects two's-complement operands.
//     The operand magnitudes are captured on accept.
//     A NEG cycle applies the result sign.
//     When undefined, the block is unsigned only and sgn is ignored.
//
// Ports:
//   clk      in   1      clock, rising edge
//   reset    in   1      asynchronous, active-high reset
//   start    in   1      request; accepted in IDLE or DONE
//   a        in   WIDTH  multiplicand, captured on accept
//   b        in   WIDTH  multiplier, captured on accept
//   sgn      in   1      two's-complement operands (signed build only)
//   busy     out  1      high in RUN and NEG
//   done     out  1      one-cycle pulse: product valid
//   prod_hi  out  WIDTH  upper half of the product register
//   prod_lo  out  WIDTH  lower half of the product register

module iter_mul_hs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;

  // In the unsigned build, NEG is never entered.
  // The last iteration therefore goes straight to DONE.
`ifdef ITER_MUL_SIGNED_EN
  localparam state_t AFTER_RUN = NEG;
`else
  localparam state_t AFTER_RUN = DONE;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_in;
  logic [WIDTH-1:0] m_sel;
  logic [WIDTH:0]   sum;

`ifdef ITER_MUL_SIGNED_EN
  // -(-2^(W-1)) wraps to 2^(W-1).
  // That value is still correct when the result is read as an unsigned magnitude.
  assign a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
  assign neg_in = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign a_mag      = a;
  assign b_mag      = b;
  assign neg_in     = 1'b0;
`endif

  assign m_sel = lo_q[0] ? m_q : '0;
  assign sum   = {1'b0, hi_q} + {1'b0, m_sel};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = a_mag;
          hi_d    = '0;
          lo_d    = b_mag;
          cnt_d   = CNT_LOAD;
          neg_d   = neg_in;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The carry out of the add enters the MSB as the pair shifts right.
        {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
        cnt_d        = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          state_d = AFTER_RUN;
        end
      end
      NEG: begin
        if (neg_q) begin
          {hi_d, lo_d} = -{hi_q, lo_q};
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == RUN) || (state_q == NEG);
  assign done    = (state_q == DONE);
  assign prod_hi = hi_q;
  assign prod_lo = lo_q;

endmodule

// File: tb/tb_iter_mul_hs.sv
// tb/tb_iter_mul_hs.sv - directed self-checking bench for iter_mul_hs (WIDTH=8)

module tb_iter_mul_hs;

  localparam int W = 8;
`ifdef ITER_MUL_SIGNED_EN
  localparam int LAT = W + 1;
  localparam logic SIGNED_BUILD = 1'b1;
`else
  localparam int LAT = W;
  localparam logic SIGNED_BUILD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         sgn;
  logic         busy, done;
  logic [W-1:0] prod_hi, prod_lo;

  int checks = 0;
  int errors = 0;
  int n;

  iter_mul_hs #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .sgn     (sgn),
    .busy    (busy),
    .done    (done),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive start for one accept edge.
  // On return, time is 1 unit after the accept edge.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
    a     = ta;
    b     = tb_v;
    sgn   = ts;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count the edges after the accept edge until done rises.
  // The count is bounded.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sgn   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_prod", 32'({prod_hi, prod_lo}), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 255 * 255
    launch(8'd255, 8'd255, 1'b0);
    check("ff_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("ff_lat", 32'(n), 32'(LAT));
    check("ff_prod", 32'({prod_hi, prod_lo}), 32'hFE01);
    @(posedge clk);
    #1;
    check("ff_done_pulse", 32'(done), 32'd0);
    a = 8'h12;
    b = 8'h34;
    repeat (2) @(posedge clk);
    #1;
    check("ff_hold", 32'({prod_hi, prod_lo}), 32'hFE01);

    // -3 * 5 with sgn=1
    launch(8'hFD, 8'd5, 1'b1);
    wait_done(n);
    check("m3x5_lat", 32'(n), 32'(LAT));
    check("m3x5_prod", 32'({prod_hi, prod_lo}), SIGNED_BUILD ? 32'hFFF1 : 32'h04F1);

    // -128 * -128, which gives the same bits in both builds
    launch(8'h80, 8'h80, 1'b1);
    wait_done(n);
    check("m128sq_prod", 32'({prod_hi, prod_lo}), 32'h4000);

    // Zero operand, then hold with toggling inputs
    launch(8'h00, 8'hA5, 1'b0);
    wait_done(n);
    check("zero_prod", 32'({prod_hi, prod_lo}), 32'h0);
    for (int i = 0; i < 4; i++) begin
      a = 8'(i * 37 + 1);
      b = ~a;
      @(posedge clk);
      #1;
      check("zero_hold_done", 32'(done), 32'd0);
      check("zero_hold_prod", 32'({prod_hi, prod_lo}), 32'h0);
    end

    // start held through RUN with new operands, then a back-to-back accept from DONE
    a     = 8'd3;
    b     = 8'd4;
    sgn   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'd10;
    b = 8'd10;
    wait_done(n);
    check("held_lat", 32'(n), 32'(LAT));
    check("held_prod", 32'({prod_hi, prod_lo}), 32'h000C);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done", 32'(done), 32'd0);
    wait_done(n);
    check("b2b_lat", 32'(n), 32'(LAT));
    check("b2b_prod", 32'({prod_hi, prod_lo}), 32'h0064);

    // Reset asserted at iteration 4
    launch(8'd255, 8'd255, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_prod", 32'({prod_hi, prod_lo}), 32'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort_nodone", 32'(done), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    launch(8'd7, 8'd6, 1'b0);
    wait_done(n);
    check("post_rst_lat", 32'(n), 32'(LAT));
    check("post_rst_prod", 32'({prod_hi, prod_lo}), 32'h002A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
